// File: rtl/dmem_mmio_responder.sv
`timescale 1ns/1ps
// dmem_mmio_responder
// Splits the processor's 12-bit data-memory space into RAM and an MMIO window.
// The MMIO window holds a keyboard scancode FIFO, a frame-tick counter and an LED
// register. All reads are combinational from the current registers; all writes
// take effect on the rising edge where wren is sampled.
//
// Keyboard input handshake: kb_valid is a one-cycle strobe with no back-pressure.
// Every cycle where kb_valid is high presents one scancode on kb_data, and the
// responder accepts it on that edge unconditionally. When the FIFO is full and no
// pop happens on the same edge, the byte is dropped and the sticky ovf flag is set.
module dmem_mmio_responder #(
    parameter logic [11:0] MMIO_BASE = 12'hF00,
    parameter int          KB_DEPTH  = 8,
    parameter int          TICK_DIV  = 833333
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        ram_wren,
    input  logic [31:0] q_ram,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic [15:0] led,
    output logic        tick_pulse
);

    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = $clog2(KB_DEPTH + 1);
    localparam int PRE_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KB_DEPTH);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // Register offsets inside the MMIO window
    localparam logic [11:0] OFF_KEY_DATA = 12'd0;
    localparam logic [11:0] OFF_KEY_POP  = 12'd1;
    localparam logic [11:0] OFF_TICK     = 12'd2;
    localparam logic [11:0] OFF_LED      = 12'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem_q [KB_DEPTH];
    logic [7:0]       fifo_mem_d [KB_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [PRE_W-1:0] prescaler_q, prescaler_d;
    logic [31:0]      tick_count_q, tick_count_d;
    logic             tick_pulse_q, tick_pulse_d;

    logic [15:0]      led_q, led_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic        mmio;
    logic [11:0] mmio_off;
    logic        pop_wr;
    logic        tick_wr;
    logic        led_wr;

    // Address decode and per-register write strobes
    always_comb begin
        mmio     = (address_dmem >= MMIO_BASE);
        mmio_off = address_dmem - MMIO_BASE;
        ram_wren = wren & ~mmio;
        pop_wr   = wren & mmio & (mmio_off == OFF_KEY_POP);
        tick_wr  = wren & mmio & (mmio_off == OFF_TICK);
        led_wr   = wren & mmio & (mmio_off == OFF_LED);
    end

    // ------------------------------------------------------------------
    // Keyboard FIFO
    // ------------------------------------------------------------------
    logic fifo_empty;
    logic fifo_full;
    logic do_pop;
    logic do_push;

    // A pop frees a slot on the same edge, so a push into a full FIFO still lands
    // when it coincides with a pop; a pop on an empty FIFO is ignored.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        do_pop     = pop_wr & ~fifo_empty;
        do_push    = kb_valid & (~fifo_full | do_pop);
    end

    // Next-state for storage, pointers, occupancy and the sticky overflow flag
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        if (do_push) begin
            fifo_mem_d[wr_ptr_q] = kb_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Any KEY_POP write acknowledges the overflow, whether or not data was popped
        if (pop_wr) begin
            ovf_d = 1'b0;
        end else if (kb_valid && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame tick and LED register
    // ------------------------------------------------------------------

    // Prescaler/tick counter next-state; a software TICK write beats a natural tick
    always_comb begin
        prescaler_d  = prescaler_q;
        tick_count_d = tick_count_q;
        tick_pulse_d = 1'b0;

        if (tick_wr) begin
            tick_count_d = data;
            prescaler_d  = '0;
        end else if (prescaler_q == PRE_LAST) begin
            prescaler_d  = '0;
            tick_count_d = tick_count_q + 32'd1;
            tick_pulse_d = 1'b1;
        end else begin
            prescaler_d = prescaler_q + PRE_W'(1);
        end
    end

    // LED register next-state
    always_comb begin
        led_d = led_q;
        if (led_wr) begin
            led_d = data[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [7:0]  fifo_head;
    logic [31:0] mmio_rdata;

    // MMIO read data from current registers, then RAM/MMIO select
    always_comb begin
        fifo_head = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];
        case (mmio_off)
            OFF_KEY_DATA: mmio_rdata = {22'b0, ovf_q, ~fifo_empty, fifo_head};
            OFF_TICK:     mmio_rdata = tick_count_q;
            OFF_LED:      mmio_rdata = {16'b0, led_q};
            default:      mmio_rdata = 32'd0;
        endcase
        q_dmem = mmio ? mmio_rdata : q_ram;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // All state updates; reset discards FIFO contents and overrides same-edge activity
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < KB_DEPTH; i++) begin
                fifo_mem_q[i] <= 8'h00;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            prescaler_q  <= '0;
            tick_count_q <= 32'd0;
            tick_pulse_q <= 1'b0;
            led_q        <= 16'h0000;
        end else begin
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            prescaler_q  <= prescaler_d;
            tick_count_q <= tick_count_d;
            tick_pulse_q <= tick_pulse_d;
            led_q        <= led_d;
        end
    end

    assign led        = led_q;
    assign tick_pulse = tick_pulse_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
`timescale 1ns/1ps
// Directed bench for dmem_mmio_responder with KB_DEPTH=8 and TICK_DIV=4.
// Inputs are driven at the falling edge; outputs are sampled away from the rising edge.
module tb_dmem_mmio_responder;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address_dmem = 12'h000;
    logic [31:0] data = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic        ram_wren;
    logic [31:0] q_ram = 32'd0;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic [15:0] led;
    logic        tick_pulse;

    always #5 clock = ~clock;

    dmem_mmio_responder #(
        .MMIO_BASE (12'hF00),
        .KB_DEPTH  (8),
        .TICK_DIV  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_wren     (ram_wren),
        .q_ram        (q_ram),
        .kb_valid     (kb_valid),
        .kb_data      (kb_data),
        .led          (led),
        .tick_pulse   (tick_pulse)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks (entered and left at a falling edge)
    // ------------------------------------------------------------------
    task automatic do_write(input logic [11:0] a, input logic [31:0] d);
        address_dmem = a;
        data         = d;
        wren         = 1'b1;
        #1;
        exp_q.push_back({31'b0, (a < 12'hF00)});
        check("ram_wren", {31'b0, ram_wren});
        @(negedge clock);
        wren = 1'b0;
    endtask

    task automatic do_pop();
        do_write(12'hF01, 32'hDEAD_BEEF);
    endtask

    task automatic push_kb(input logic [7:0] b);
        kb_data  = b;
        kb_valid = 1'b1;
        @(negedge clock);
        kb_valid = 1'b0;
    endtask

    task automatic push_and_pop(input logic [7:0] b);
        kb_data      = b;
        kb_valid     = 1'b1;
        address_dmem = 12'hF01;
        data         = 32'd0;
        wren         = 1'b1;
        @(negedge clock);
        kb_valid = 1'b0;
        wren     = 1'b0;
    endtask

    task automatic expect_read(input string tag, input logic [11:0] a, input logic [31:0] e);
        address_dmem = a;
        wren         = 1'b0;
        exp_q.push_back(e);
        #1;
        check(tag, q_dmem);
        @(negedge clock);
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] ram_word;

    initial begin
        // Reset
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        expect_read("reset_tick", 12'hF02, 32'd0);
        expect_read("reset_key", 12'hF00, 32'd0);
        exp_q.push_back(32'd0);
        check("reset_led", {16'b0, led});

        // Decode
        do_write(12'h010, 32'h0000_1234);
        do_write(12'hF03, 32'h0000_1234);
        exp_q.push_back(32'h0000_1234);
        check("led_out", {16'b0, led});
        expect_read("led_read", 12'hF03, 32'h0000_1234);
        ram_word = $urandom();
        q_ram    = ram_word;
        expect_read("ram_read", 12'h010, ram_word);
        ram_word = $urandom();
        q_ram    = ram_word;
        expect_read("ram_read_edge", 12'hEFF, ram_word);
        expect_read("unmapped_f04", 12'hF04, 32'd0);
        expect_read("unmapped_fff", 12'hFFF, 32'd0);
        expect_read("pop_reads_zero", 12'hF01, 32'd0);
        do_write(12'hF05, 32'h0000_5555);
        expect_read("led_after_unmapped_wr", 12'hF03, 32'h0000_1234);

        // FIFO order
        push_kb(8'h1C);
        push_kb(8'h32);
        push_kb(8'h23);
        expect_read("fifo_head0", 12'hF00, 32'h0000_011C);
        expect_read("fifo_read_no_side_effect", 12'hF00, 32'h0000_011C);
        do_pop();
        expect_read("fifo_head1", 12'hF00, 32'h0000_0132);
        do_pop();
        expect_read("fifo_head2", 12'hF00, 32'h0000_0123);
        do_pop();
        expect_read("fifo_empty", 12'hF00, 32'h0000_0000);
        do_pop();
        expect_read("fifo_pop_on_empty", 12'hF00, 32'h0000_0000);

        // Overflow
        for (int i = 1; i <= 9; i++) push_kb(8'(i));
        expect_read("ovf_head", 12'hF00, 32'h0000_0301);
        for (int i = 2; i <= 8; i++) begin
            do_pop();
            expect_read("ovf_drain", 12'hF00, 32'h0000_0100 | 32'(i));
        end
        do_pop();
        expect_read("ovf_drained", 12'hF00, 32'h0000_0000);

        // Simultaneous push+pop on a full FIFO
        for (int i = 1; i <= 8; i++) push_kb(8'(i));
        expect_read("full_head", 12'hF00, 32'h0000_0101);
        push_and_pop(8'hAA);
        expect_read("full_pushpop", 12'hF00, 32'h0000_0102);
        push_kb(8'hBB);
        expect_read("still_full_ovf", 12'hF00, 32'h0000_0302);
        for (int i = 3; i <= 8; i++) begin
            do_pop();
            expect_read("full_drain", 12'hF00, 32'h0000_0100 | 32'(i));
        end
        do_pop();
        expect_read("aa_last", 12'hF00, 32'h0000_01AA);
        do_pop();
        expect_read("full_drained", 12'hF00, 32'h0000_0000);

        // Simultaneous push+pop on an empty FIFO
        push_and_pop(8'hAA);
        expect_read("empty_pushpop", 12'hF00, 32'h0000_01AA);
        do_pop();
        expect_read("empty_pushpop_drain", 12'hF00, 32'h0000_0000);

        // Tick: pulse every 4th edge after a TICK write
        do_write(12'hF02, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            exp_q.push_back({31'b0, (k % 4 == 0)});
            check("tick_pulse", {31'b0, tick_pulse});
            exp_q.push_back(32'(k / 4));
            check("tick_count", q_dmem);
        end

        // Tick: wrap from all-ones
        do_write(12'hF02, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        check("tick_loaded", q_dmem);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            exp_q.push_back({31'b0, (k == 4)});
            check("wrap_pulse", {31'b0, tick_pulse});
            exp_q.push_back((k == 4) ? 32'd0 : 32'hFFFF_FFFF);
            check("wrap_count", q_dmem);
        end

        // Tick: TICK write on the tick edge wins
        do_write(12'hF02, 32'd0);
        for (int k = 1; k <= 3; k++) @(negedge clock);
        do_write(12'hF02, 32'h0000_0077);
        exp_q.push_back(32'd0);
        check("write_wins_pulse", {31'b0, tick_pulse});
        exp_q.push_back(32'h0000_0077);
        check("write_wins_count", q_dmem);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            exp_q.push_back({31'b0, (k == 4)});
            check("post_write_pulse", {31'b0, tick_pulse});
            exp_q.push_back((k == 4) ? 32'h0000_0078 : 32'h0000_0077);
            check("post_write_count", q_dmem);
        end

        // Reset mid-operation
        push_kb(8'h11);
        push_kb(8'h22);
        push_kb(8'h33);
        do_write(12'hF03, 32'h0000_FFFF);
        do_write(12'hF02, 32'd5);
        expect_read("pre_reset_led", 12'hF03, 32'h0000_FFFF);
        expect_read("pre_reset_key", 12'hF00, 32'h0000_0111);
        reset    = 1'b1;
        kb_valid = 1'b1;
        kb_data  = 8'h55;
        @(negedge clock);
        reset    = 1'b0;
        kb_valid = 1'b0;
        expect_read("post_reset_tick", 12'hF02, 32'd0);
        expect_read("post_reset_key", 12'hF00, 32'd0);
        expect_read("post_reset_led", 12'hF03, 32'd0);
        exp_q.push_back(32'd0);
        check("post_reset_led_out", {16'b0, led});
        exp_q.push_back(32'd0);
        check("post_reset_pulse", {31'b0, tick_pulse});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
